pc_incrementer: RTL and testbench

Program-counter incrementer for the instruction-fetch stage: next-PC = PC + STEP.
- Combinational result feeds the PC mux in the same cycle.
- A clock-enabled registered copy, with a valid strobe and an overflow flag, serves the pipelined fetch path and debug.
- Default STEP of 1 matches word-indexed instruction memory.

---
 rtl/pc_incrementer.sv | 56 +++++
 tb/tb_pc_incrementer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_incrementer.sv
// PC incrementer: pcout = pcin + STEP, with a clock-enabled registered copy.
// Define PC_INCREMENTER_SAT_EN to saturate at all-ones on overflow instead of wrapping.
module pc_incrementer #(
    parameter int unsigned           WIDTH = 32,
    parameter logic [WIDTH-1:0]      STEP  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] pcin,
    output logic [WIDTH-1:0] pcout,
    output logic             wrap,
    output logic [WIDTH-1:0] pcout_q,
    output logic             wrap_q,
    output logic             valid_q
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] pcout_d;
    logic             wrap_d;
    logic             valid_d;

    assign sum  = {1'b0, pcin} + {1'b0, STEP};
    assign wrap = sum[WIDTH];

`ifdef PC_INCREMENTER_SAT_EN
    assign pcout = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign pcout = sum[WIDTH-1:0];
`endif

    always_comb begin
        pcout_d = pcout_q;
        wrap_d  = wrap_q;
        valid_d = 1'b0;
        if (en) begin
            pcout_d = pcout;
            wrap_d  = wrap;
            valid_d = 1'b1;
        end
    end

    // Reset wins over en: a capture on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcout_q <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pcout_q <= pcout_d;
            wrap_q  <= wrap_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_pc_incrementer.sv
// Directed bench for pc_incrementer (STEP=1 and STEP=4 instances).
module tb_pc_incrementer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] pcin;
    logic [31:0] pcout;
    logic        wrap;
    logic [31:0] pcout_q;
    logic        wrap_q;
    logic        valid_q;

    logic [31:0] pcin4;
    logic [31:0] pcout4;
    logic        wrap4;
    logic [31:0] pcout_q4;
    logic        wrap_q4;
    logic        valid_q4;

    int vectors = 0;
    int fails   = 0;

`ifdef PC_INCREMENTER_SAT_EN
    localparam logic [31:0] OVF1 = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF1 = 32'h0000_0000;
`endif

    pc_incrementer #(.WIDTH(32), .STEP(32'd1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .pcin(pcin),
        .pcout(pcout), .wrap(wrap), .pcout_q(pcout_q),
        .wrap_q(wrap_q), .valid_q(valid_q)
    );

    pc_incrementer #(.WIDTH(32), .STEP(32'd4)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .pcin(pcin4),
        .pcout(pcout4), .wrap(wrap4), .pcout_q(pcout_q4),
        .wrap_q(wrap_q4), .valid_q(valid_q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        pcin  = 32'd0;
        pcin4 = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_pcout_q", pcout_q, 32'd0);
        chk("rst_wrap_q", {31'd0, wrap_q}, 32'd0);
        chk("rst_valid_q", {31'd0, valid_q}, 32'd0);
        chk("rst_valid_q4", {31'd0, valid_q4}, 32'd0);

        rst_n = 1'b1;
        pcin = 32'd3;
        #1;
        chk("comb_3", pcout, 32'd4);
        chk("comb_3_wrap", {31'd0, wrap}, 32'd0);
        #9;
        pcin = 32'd15;
        #1;
        chk("comb_15", pcout, 32'd16);
        chk("comb_15_wrap", {31'd0, wrap}, 32'd0);
        #9;
        pcin = 32'd64;
        #1;
        chk("comb_64", pcout, 32'd65);
        chk("comb_64_wrap", {31'd0, wrap}, 32'd0);
        chk("en0_pcout_q", pcout_q, 32'd0);
        chk("en0_valid_q", {31'd0, valid_q}, 32'd0);
        #9;
        pcin = 32'hFFFF_FFFF;
        #1;
        chk("comb_max", pcout, OVF1);
        chk("comb_max_wrap", {31'd0, wrap}, 32'd1);

        @(negedge clk);
        pcin = 32'd64;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        chk("cap_pcout_q", pcout_q, 32'd65);
        chk("cap_wrap_q", {31'd0, wrap_q}, 32'd0);
        chk("cap_valid_q", {31'd0, valid_q}, 32'd1);
        pcin = 32'd7;
        @(posedge clk);
        #1;
        chk("hold_valid_q", {31'd0, valid_q}, 32'd0);
        chk("hold_pcout_q", pcout_q, 32'd65);

        @(negedge clk);
        pcin = 32'd10;
        pcin4 = 32'd8;
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("seq_10", pcout_q, 32'd11);
        chk("seq_10_valid", {31'd0, valid_q}, 32'd1);
        chk("seq_u4_8", pcout_q4, 32'd12);
        pcin = 32'd20;
        @(posedge clk);
        #1;
        chk("seq_20", pcout_q, 32'd21);
        chk("seq_20_valid", {31'd0, valid_q}, 32'd1);
        pcin = 32'd30;
        @(posedge clk);
        #1;
        chk("seq_30", pcout_q, 32'd31);
        chk("seq_30_valid", {31'd0, valid_q}, 32'd1);
        pcin = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        chk("ovf_pcout_q", pcout_q, OVF1);
        chk("ovf_wrap_q", {31'd0, wrap_q}, 32'd1);
        en = 1'b0;
        pcin = 32'd5;
        @(posedge clk);
        #1;
        chk("ovf_hold_wrap_q", {31'd0, wrap_q}, 32'd1);

        @(negedge clk);
        en = 1'b1;
        pcin = 32'd100;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pcout_q", pcout_q, 32'd0);
        chk("midrst_wrap_q", {31'd0, wrap_q}, 32'd0);
        chk("midrst_valid_q", {31'd0, valid_q}, 32'd0);
        chk("midrst_pcout", pcout, 32'd101);
        rst_n = 1'b1;
        en = 1'b0;

        pcin4 = 32'hFFFF_FFFC;
`ifdef PC_INCREMENTER_SAT_EN
        #1;
        chk("s4_fffc", pcout4, 32'hFFFF_FFFF);
`else
        #1;
        chk("s4_fffc", pcout4, 32'h0000_0000);
`endif
        chk("s4_fffc_wrap", {31'd0, wrap4}, 32'd1);
        pcin4 = 32'hFFFF_FFFB;
        #1;
        chk("s4_fffb", pcout4, 32'hFFFF_FFFF);
        chk("s4_fffb_wrap", {31'd0, wrap4}, 32'd0);
        pcin4 = 32'h0000_1000;
        #1;
        chk("s4_1000", pcout4, 32'h0000_1004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
